// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit, one bit per cycle (shift-add / restoring divide).
// Define OSIRIS_MULDIV_DIV_EN to build the divider; otherwise ops 100-111 complete as illegal.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid_EX,
  output logic             o_ready_EX,
  input  logic [2:0]       i_op_EX,
  input  logic [WIDTH-1:0] i_rs1_EX,
  input  logic [WIDTH-1:0] i_rs2_EX,
  input  logic             i_flush_EX,
  output logic             o_valid_EX,
  output logic [WIDTH-1:0] o_result_EX,
  output logic             o_illegal_EX
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2:0]         op_q;
  logic               sign1_q;
  logic               sign2_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               valid_q;
  logic               illegal_q;
  logic [WIDTH-1:0]   result_q;

  // Request decode: signedness per operand, then magnitudes.
  logic             rs1_signed;
  logic             rs2_signed;
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  assign rs1_signed = (i_op_EX == 3'b001) | (i_op_EX == 3'b010) |
                      (i_op_EX == 3'b100) | (i_op_EX == 3'b110);
  assign rs2_signed = (i_op_EX == 3'b001) | (i_op_EX == 3'b100) | (i_op_EX == 3'b110);
  assign sign1      = rs1_signed & i_rs1_EX[WIDTH-1];
  assign sign2      = rs2_signed & i_rs2_EX[WIDTH-1];
  assign mag1       = sign1 ? -i_rs1_EX : i_rs1_EX;
  assign mag2       = sign2 ? -i_rs2_EX : i_rs2_EX;

  // Multiply step: conditionally add multiplicand into the high half, shift right.
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] acc_step;

  assign mul_addend = acc_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef OSIRIS_MULDIV_DIV_EN
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  // Restoring divide: acc = {remainder, dividend/quotient}, quotient bits shift in at LSB.
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   short_res;

  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, opnd_q};
  assign div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign acc_step  = op_q[2] ? div_next : mul_next;

  assign div_zero  = (i_rs2_EX == '0);
  assign div_ovf   = ~i_op_EX[0] & (i_rs1_EX == MinNeg) & (&i_rs2_EX);
  always_comb begin
    short_res = '0;
    if (i_op_EX[1]) short_res = div_zero ? i_rs1_EX : '0;
    else            short_res = div_zero ? '1 : i_rs1_EX;
  end
`else
  assign acc_step  = mul_next;
`endif

  // Sign correction and half/quotient/remainder selection.
  logic               res_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_res;

  assign res_neg = sign1_q ^ sign2_q;
  assign prod    = res_neg ? -acc_q : acc_q;

  always_comb begin
    fix_res = '0;
    unique case (op_q)
      3'b000:                 fix_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
`ifdef OSIRIS_MULDIV_DIV_EN
      3'b100, 3'b101: fix_res = res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      3'b110, 3'b111: fix_res = sign1_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
      default:                fix_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else if (i_flush_EX) begin
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_valid_EX) begin
            op_q    <= i_op_EX;
            sign1_q <= sign1;
            sign2_q <= sign2;
            cnt_q   <= '0;
            if (i_op_EX[2]) begin
`ifdef OSIRIS_MULDIV_DIV_EN
              opnd_q <= mag2;
              acc_q  <= {{WIDTH{1'b0}}, mag1};
              if (div_zero || div_ovf) begin
                state_q  <= StDone;
                valid_q  <= 1'b1;
                result_q <= short_res;
              end else begin
                state_q <= StCalc;
              end
`else
              state_q   <= StDone;
              valid_q   <= 1'b1;
              illegal_q <= 1'b1;
              result_q  <= '0;
`endif
            end else begin
              opnd_q  <= mag1;
              acc_q   <= {{WIDTH{1'b0}}, mag2};
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) state_q <= StFix;
        end
        StFix: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          state_q  <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready_EX   = (state_q == StIdle);
  assign o_valid_EX   = valid_q;
  assign o_result_EX  = result_q;
  assign o_illegal_EX = illegal_q;

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand/result width; even, >= 8.
REQ-002 The block SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 The block SHALL have port i_valid_EX  input  1  request strobe, accepted only while o_ready_EX=1.
REQ-005 The block SHALL have port o_ready_EX  output  1  high only in IDLE.
REQ-006 The block SHALL have port i_op_EX  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 The block SHALL have ports i_rs1_EX and i_rs2_EX  input  WIDTH  operands (rs1 = multiplicand/dividend).
REQ-008 The block SHALL have port i_flush_EX  input  1  abort of any operation in flight.
REQ-009 The block SHALL have port o_valid_EX  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port o_result_EX  output  WIDTH  registered result, held until the next completion.
REQ-011 The block SHALL have port o_illegal_EX  output  1  registered; high with o_valid_EX for an unsupported op.

Function
REQ-012 FSM states SHALL be IDLE, CALC, FIX, DONE; encoding is free.
REQ-013 Accept = i_valid_EX & o_ready_EX & !i_flush_EX at a rising edge; op and operands latched, signs recorded, magnitudes taken.
REQ-014 IDLE->CALC on accept; CALC SHALL run exactly WIDTH iterations (one bit per cycle, shift-add multiply / restoring divide) under a log2(WIDTH)+1-bit counter.
REQ-015 CALC->FIX after the last iteration; FIX applies sign correction and selects low/high product half or quotient/remainder; FIX->DONE; DONE->IDLE unconditionally.
REQ-016 o_valid_EX SHALL be high only in DONE, i.e. WIDTH+2 rising edges after the accepting edge; no backpressure.
REQ-017 MUL returns product bits [WIDTH-1:0]; MULH/MULHSU/MULHU return bits [2*WIDTH-1:WIDTH] with signed x signed, signed x unsigned, unsigned x unsigned interpretation.
REQ-018 DIV/REM round toward zero; remainder sign equals dividend sign.
REQ-019 Divide by zero: quotient all-ones, remainder = rs1; resolved at accept, IDLE->DONE directly, o_valid_EX one edge after acceptance.
REQ-020 Signed overflow (rs1 = most-negative, rs2 = all-ones, DIV/REM): quotient = rs1, remainder 0; same short path as REQ-019.
REQ-021 i_flush_EX high at an edge SHALL force IDLE from any state, suppress o_valid_EX, leave o_result_EX unchanged; flush with i_valid_EX in IDLE SHALL not accept.
REQ-022 A new request MAY be accepted in the cycle after DONE (back-to-back, one idle cycle).
REQ-023 o_illegal_EX SHALL be 0 on every completion when the block is fully configured.

Reset
REQ-024 On i_rst_n low, asynchronously: state IDLE, counter 0, o_ready_EX=1, o_valid_EX=0, o_result_EX=0, o_illegal_EX=0, operand/accumulator registers 0.
REQ-025 Reset during CALC/FIX/DONE SHALL abort without a completion pulse; operation resumes only on a new accept after reset release.

Configuration
REQ-026 Macro OSIRIS_MULDIV_DIV_EN defined: divider datapath and ops 100-111 SHALL be built as specified.
REQ-027 Macro undefined: no divider logic; ops 100-111 SHALL go IDLE->DONE with o_result_EX=0, o_illegal_EX=1, o_valid_EX one edge after acceptance; multiply ops unchanged.

Verification (WIDTH=32)
REQ-028 MUL rs1=7, rs2=0xFFFFFFFD -> o_result_EX=0xFFFFFFEB, o_valid_EX 34 edges after accept, one cycle wide.
REQ-029 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-030 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5 one edge after accept.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, short latency, o_illegal_EX=0.
REQ-032 MUL accepted, i_flush_EX at edge 10 -> no o_valid_EX, o_ready_EX=1 next cycle, o_result_EX unchanged; i_rst_n low mid-CALC -> all outputs at reset values immediately.
REQ-033 Macro undefined: DIVU 9/3 -> o_valid_EX=1, o_illegal_EX=1, o_result_EX=0 one edge after accept; back-to-back MUL then MULHU both complete correctly.
